// File: rtl/alu_console_pkg.sv
// Shared types and constants for the ALU operand console: FSM states, input_sel codes,
// status word layout and display labels.
package alu_console_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [2:0] SelCtrl  = 3'b000;
  localparam logic [2:0] SelSrc1  = 3'b001;
  localparam logic [2:0] SelSrc2  = 3'b010;
  localparam logic [2:0] SelGo    = 3'b011;
  localparam logic [2:0] SelClear = 3'b100;

  localparam int unsigned StatStateLsb = 0;
  localparam int unsigned StatRejBit   = 2;
  localparam int unsigned StatTmoBit   = 3;
  localparam int unsigned StatOpCntLsb = 8;

  localparam logic [39:0] LabelCtrl  = "CTRL ";
  localparam logic [39:0] LabelStat  = "STAT ";
  localparam logic [31:0] PrefixSrc1 = "S1_W";
  localparam logic [31:0] PrefixSrc2 = "S2_W";
  localparam logic [31:0] PrefixRes  = "RS_W";

  // Four-character prefix followed by the ASCII digit of the word index.
  function automatic logic [39:0] word_label(input logic [31:0] prefix, input int unsigned k);
    logic [7:0] digit;
    digit = 8'h30 + 8'(k);
    return {prefix, digit};
  endfunction

endpackage

// File: rtl/alu_console_if.sv
// ALU-side request/ack/done handshake bundle; the console drives the master modport.
interface alu_console_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 12
);
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic              alu_req;
  logic              alu_ack;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output alu_control, alu_src1, alu_src2, alu_req,
    input  alu_ack, alu_done, alu_result
  );

  modport slave (
    input  alu_control, alu_src1, alu_src2, alu_req,
    output alu_ack, alu_done, alu_result
  );
endinterface

// File: rtl/alu_console_disp.sv
// Display-slot decode for lcd_module: maps a slot number to a label and value, registered
// so the outputs follow display_number with one cycle of latency.
module alu_console_disp
  import alu_console_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        display_number,
  input  logic [31:0]       ctrl_word,
  input  logic [31:0]       status_word,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] result,
  output logic              display_valid,
  output logic [39:0]       display_name,
  output logic [31:0]       display_value
);
  localparam int unsigned W = DATA_W / 32;

  logic        valid_d;
  logic [39:0] name_d;
  logic [31:0] value_d;

  always_comb begin
    valid_d = 1'b0;
    name_d  = '0;
    value_d = '0;
    if (display_number == 6'd1) begin
      valid_d = 1'b1;
      name_d  = LabelCtrl;
      value_d = ctrl_word;
    end else if (display_number == 6'd2) begin
      valid_d = 1'b1;
      name_d  = LabelStat;
      value_d = status_word;
    end else begin
      // Three banks of W slots each: src1 words, src2 words, result words.
      for (int unsigned k = 0; k < W; k++) begin
        if (display_number == 6'(3 + k)) begin
          valid_d = 1'b1;
          name_d  = word_label(PrefixSrc1, k);
          value_d = src1[32*k +: 32];
        end
        if (display_number == 6'(3 + W + k)) begin
          valid_d = 1'b1;
          name_d  = word_label(PrefixSrc2, k);
          value_d = src2[32*k +: 32];
        end
        if (display_number == 6'(3 + 2*W + k)) begin
          valid_d = 1'b1;
          name_d  = word_label(PrefixRes, k);
          value_d = result[32*k +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= valid_d;
      display_name  <= name_d;
      display_value <= value_d;
    end
  end

endmodule

// File: rtl/alu_operand_console.sv
// Touchscreen operand/command console: assembles wide operands, issues one ALU operation at a
// time over req/ack/done and exposes state on the lcd display mux. Optional: ALU_TIMEOUT_EN.
module alu_operand_console
  import alu_console_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned CTRL_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [2:0]   input_sel,
  input  logic         input_valid,
  input  logic [31:0]  input_value,
  input  logic [5:0]   display_number,
  output logic         display_valid,
  output logic [39:0]  display_name,
  output logic [31:0]  display_value,
  output logic         busy,
  alu_console_if.master alu
);
  localparam int unsigned W    = DATA_W / 32;
  localparam int unsigned PtrW = (W > 1) ? $clog2(W) : 1;

  state_e            state_q;
  logic              req_q;
  logic              rej_q;
  logic              tmo_q;
  logic [15:0]       op_cnt_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] result_q;
  logic [PtrW-1:0]   wp1_q;
  logic [PtrW-1:0]   wp2_q;
  logic [2:0]        last_sel_q;

  logic            is_op_sel;
  logic            wr_take;
  logic            wr_drop;
  logic            wr_clear;
  logic            wr_accept;
  logic            sel_change;
  logic [PtrW-1:0] idx1;
  logic [PtrW-1:0] idx2;
  logic            timeout_hit;
  logic [31:0]     status_word;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    if (W == 1 || p == PtrW'(W - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign busy = (state_q != StIdle);

  always_comb begin
    is_op_sel  = input_sel inside {SelCtrl, SelSrc1, SelSrc2, SelGo};
    wr_take    = input_valid && is_op_sel && !busy;
    wr_drop    = input_valid && is_op_sel && busy;
    wr_clear   = input_valid && (input_sel == SelClear);
    wr_accept  = wr_take || wr_clear;
    sel_change = (input_sel != last_sel_q);
    // A change of target restarts word entry at word 0 for both operands.
    idx1       = sel_change ? '0 : wp1_q;
    idx2       = sel_change ? '0 : wp2_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      wp1_q      <= '0;
      wp2_q      <= '0;
      last_sel_q <= SelCtrl;
    end else if (wr_accept) begin
      last_sel_q <= input_sel;
      if (sel_change) begin
        wp1_q <= '0;
        wp2_q <= '0;
      end
      if (wr_take) begin
        unique case (input_sel)
          SelCtrl: ctrl_q <= input_value[CTRL_W-1:0];
          SelSrc1: begin
            src1_q[{idx1, 5'b0} +: 32] <= input_value;
            wp1_q                      <= ptr_next(idx1);
          end
          SelSrc2: begin
            src2_q[{idx2, 5'b0} +: 32] <= input_value;
            wp2_q                      <= ptr_next(idx2);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (state_q inside {StIssue, StWait}) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q inside {StIssue, StWait}) &&
                       (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
`else
  // Watchdog limit is meaningless without the timeout feature.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      result_q <= '0;
      op_cnt_q <= '0;
      rej_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_take && input_sel == SelGo) begin
            state_q <= StIssue;
            req_q   <= 1'b1;
          end
        end
        StIssue: begin
          if (alu.alu_ack) begin
            req_q <= 1'b0;
            if (alu.alu_done) begin
              state_q  <= StDone;
              result_q <= alu.alu_result;
            end else begin
              state_q <= StWait;
            end
          end else if (timeout_hit) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            tmo_q   <= 1'b1;
          end
        end
        StWait: begin
          if (alu.alu_done) begin
            state_q  <= StDone;
            result_q <= alu.alu_result;
          end else if (timeout_hit) begin
            state_q <= StIdle;
            tmo_q   <= 1'b1;
          end
        end
        StDone: begin
          op_cnt_q <= op_cnt_q + 16'd1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (wr_drop) rej_q <= 1'b1;
      // Clear overrides any same-cycle completion update.
      if (wr_clear) begin
        result_q <= '0;
        op_cnt_q <= '0;
        rej_q    <= 1'b0;
        tmo_q    <= 1'b0;
      end
    end
  end

  assign status_word = {8'd0, op_cnt_q, 4'd0, tmo_q, rej_q, state_q};

  assign alu.alu_control = ctrl_q;
  assign alu.alu_src1    = src1_q;
  assign alu.alu_src2    = src2_q;
  assign alu.alu_req     = req_q;

  alu_console_disp #(
    .DATA_W(DATA_W)
  ) u_disp (
    .clk           (clk),
    .resetn        (resetn),
    .display_number(display_number),
    .ctrl_word     (32'(ctrl_q)),
    .status_word   (status_word),
    .src1          (src1_q),
    .src2          (src2_q),
    .result        (result_q),
    .display_valid (display_valid),
    .display_name  (display_name),
    .display_value (display_value)
  );

endmodule

// File: tb/tb_alu_operand_console.sv
// Self-checking bench for alu_operand_console: random operand traffic and ALU handshakes
// compared against a word-array reference model of the console.
module tb_alu_operand_console;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned CTRL_W      = 12;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned W           = DATA_W / 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [2:0]  input_sel = '0;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [5:0]  display_number = '0;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        busy;

  alu_console_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) alu_bus ();

  alu_operand_console #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .input_sel     (input_sel),
    .input_valid   (input_valid),
    .input_value   (input_value),
    .display_number(display_number),
    .display_valid (display_valid),
    .display_name  (display_name),
    .display_value (display_value),
    .busy          (busy),
    .alu           (alu_bus)
  );

  always #50 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // Reference model: operands as arrays of 32-bit words with modular write indices.
  logic [31:0]       m_s1[W];
  logic [31:0]       m_s2[W];
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_res;
  int                m_opcnt;
  bit                m_rej, m_tmo, m_busy;
  int                m_p1, m_p2, m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < W; k++) begin
      m_s1[k] = '0;
      m_s2[k] = '0;
    end
    m_ctrl = '0; m_res = '0; m_opcnt = 0;
    m_rej = 0; m_tmo = 0; m_busy = 0;
    m_p1 = 0; m_p2 = 0; m_last = 0;
  endtask

  task automatic model_write(input int sel, input logic [31:0] val);
    if (sel >= 5) return;
    if (sel != 4 && m_busy) begin
      m_rej = 1;
      return;
    end
    if (sel != m_last) begin
      m_p1 = 0;
      m_p2 = 0;
    end
    m_last = sel;
    case (sel)
      0: m_ctrl = val[CTRL_W-1:0];
      1: begin m_s1[m_p1] = val; m_p1 = (m_p1 + 1) % W; end
      2: begin m_s2[m_p2] = val; m_p2 = (m_p2 + 1) % W; end
      3: m_busy = 1;
      default: begin m_res = '0; m_opcnt = 0; m_rej = 0; m_tmo = 0; end
    endcase
  endtask

  function automatic logic [DATA_W-1:0] pack(input int which);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < W; k++) r[32*k +: 32] = (which == 1) ? m_s1[k] : m_s2[k];
    return r;
  endfunction

  function automatic void exp_slot(input int n, output logic v, output logic [39:0] nm,
                                   output logic [31:0] val);
    int g, k;
    logic [31:0] pfx;
    v = 1'b0; nm = '0; val = '0;
    if (n == 1) begin
      v = 1'b1; nm = "CTRL "; val = 32'(m_ctrl);
    end else if (n == 2) begin
      v = 1'b1; nm = "STAT ";
      val = {8'd0, 16'(m_opcnt), 4'd0, m_tmo, m_rej, 2'd0};
    end else if (n >= 3 && n < 3 + 3 * W) begin
      g = (n - 3) / W;
      k = (n - 3) % W;
      pfx = (g == 0) ? "S1_W" : (g == 1) ? "S2_W" : "RS_W";
      v = 1'b1;
      nm = {pfx, 8'(48 + k)};
      val = (g == 0) ? m_s1[k] : (g == 1) ? m_s2[k] : m_res[32*k +: 32];
    end
  endfunction

  task automatic read_slot(input int n);
    display_number = 6'(n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_display();
    logic v;
    logic [39:0] nm;
    logic [31:0] val;
    for (int n = 0; n <= 3 * W + 3; n++) begin
      read_slot(n);
      exp_slot(n, v, nm, val);
      check($sformatf("slot%0d_valid", n), 64'(display_valid), 64'(v));
      check($sformatf("slot%0d_name", n), 64'(display_name), 64'(nm));
      check($sformatf("slot%0d_value", n), 64'(display_value), 64'(val));
    end
    read_slot(63);
    check("slot63_valid", 64'(display_valid), 64'(0));
  endtask

  task automatic wr_word(input logic [2:0] sel, input logic [31:0] val);
    input_sel = sel;
    input_value = val;
    input_valid = 1'b1;
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    model_write(int'(sel), val);
    check("ctrl", 64'(alu_bus.alu_control), 64'(m_ctrl));
    check("src1", alu_bus.alu_src1, pack(1));
    check("src2", alu_bus.alu_src2, pack(2));
  endtask

  // One full operation; done_dly == 0 means ack and done arrive together.
  task automatic run_op(input int ack_dly, input int done_dly, input logic [DATA_W-1:0] res,
                        input bit freeze);
    wr_word(3'd3, $urandom);
    check("go_req", 64'(alu_bus.alu_req), 64'(1));
    check("go_busy", 64'(busy), 64'(1));
    repeat (ack_dly) begin
      @(posedge clk);
      #1;
      check("req_hold", 64'(alu_bus.alu_req), 64'(1));
    end
    alu_bus.alu_ack = 1'b1;
    if (done_dly == 0) begin
      alu_bus.alu_done = 1'b1;
      alu_bus.alu_result = res;
    end
    @(posedge clk);
    #1;
    alu_bus.alu_ack = 1'b0;
    alu_bus.alu_done = 1'b0;
    check("req_drop", 64'(alu_bus.alu_req), 64'(0));
    if (done_dly > 0) begin
      for (int i = 0; i < done_dly; i++) begin
        if (i == 0 && freeze) wr_word(3'd1, $urandom);
        else begin
          @(posedge clk);
          #1;
        end
        check("wait_busy", 64'(busy), 64'(1));
      end
      alu_bus.alu_done = 1'b1;
      alu_bus.alu_result = res;
      @(posedge clk);
      #1;
      alu_bus.alu_done = 1'b0;
      alu_bus.alu_result = {$urandom, $urandom};
    end
    check("done_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    m_res = res;
    m_opcnt = (m_opcnt + 1) & 32'hFFFF;
    m_busy = 0;
  endtask

  initial begin
    logic [2:0] sel;
    alu_bus.alu_ack = 1'b0;
    alu_bus.alu_done = 1'b0;
    alu_bus.alu_result = '0;
    model_reset();
    #5 resetn = 1'b0;
    #20;
    check("rst_req", 64'(alu_bus.alu_req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_src1", alu_bus.alu_src1, 64'(0));
    check("rst_dvalid", 64'(display_valid), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Operand entry and wrap.
    wr_word(3'd1, 32'h11111111);
    wr_word(3'd1, 32'h22222222);
    check("src1_two_words", alu_bus.alu_src1, 64'h22222222_11111111);
    wr_word(3'd1, 32'h33333333);
    check("src1_wrap", alu_bus.alu_src1, 64'h22222222_33333333);

    // Target change restarts both pointers.
    wr_word(3'd2, 32'hA);
    wr_word(3'd1, 32'hB);
    wr_word(3'd2, 32'hC);
    check("ptr_src2_w0", 64'(alu_bus.alu_src2[31:0]), 64'hC);
    check("ptr_src1_w0", 64'(alu_bus.alu_src1[31:0]), 64'hB);

    for (int i = 0; i < 24; i++) begin
      sel = 3'($urandom_range(0, 7));
      if (sel == 3'd3) sel = 3'd4;
      wr_word(sel, $urandom);
    end
    check_display();

    // Handshake with a frozen write during WAIT.
    run_op(5, 3, 64'hDEADBEEF_00000001, 1'b1);
    read_slot(3 + 2 * W);
    check("rs_w0", 64'(display_value), 64'h00000001);
    read_slot(4 + 2 * W);
    check("rs_w1", 64'(display_value), 64'hDEADBEEF);
    check_display();
    wr_word(3'd4, 32'h0);
    read_slot(2);
    check("stat_cleared", 64'(display_value), 64'(0));

    // Ack and done in the first request cycle.
    run_op(0, 0, {$urandom, $urandom}, 1'b0);
    check_display();

    for (int i = 0; i < 5; i++) begin
      wr_word(3'($urandom_range(0, 2)), $urandom);
      run_op($urandom_range(0, 3), $urandom_range(0, 4), {$urandom, $urandom}, 1'b0);
    end
    check_display();

`ifdef ALU_TIMEOUT_EN
    wr_word(3'd3, 32'h0);
    repeat (TIMEOUT_CYC - 1) @(posedge clk);
    #1;
    check("tmo_req_hold", 64'(alu_bus.alu_req), 64'(1));
    @(posedge clk);
    #1;
    check("tmo_req_drop", 64'(alu_bus.alu_req), 64'(0));
    check("tmo_idle", 64'(busy), 64'(0));
    m_busy = 0;
    m_tmo = 1;
    check_display();
    wr_word(3'd3, 32'h0);
`else
    wr_word(3'd3, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("no_tmo_req", 64'(alu_bus.alu_req), 64'(1));
    check("no_tmo_busy", 64'(busy), 64'(1));
`endif

    // Reset in the middle of WAIT; a late done must be ignored.
    alu_bus.alu_ack = 1'b1;
    @(posedge clk);
    #1;
    alu_bus.alu_ack = 1'b0;
    check("wait_entered", 64'(busy), 64'(1));
    @(posedge clk);
    #20;
    resetn = 1'b0;
    #1;
    check("async_req", 64'(alu_bus.alu_req), 64'(0));
    check("async_busy", 64'(busy), 64'(0));
    check("async_src1", alu_bus.alu_src1, 64'(0));
    check("async_ctrl", 64'(alu_bus.alu_control), 64'(0));
    check("async_dvalid", 64'(display_valid), 64'(0));
    check("async_dname", 64'(display_name), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    alu_bus.alu_done = 1'b1;
    alu_bus.alu_result = {$urandom, $urandom};
    @(posedge clk);
    #1;
    alu_bus.alu_done = 1'b0;
    check("late_done_busy", 64'(busy), 64'(0));
    check_display();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
